// File: rtl/mr_uart_pkg.sv
// Shared definitions for the Wishbone transmit-only console UART:
// bus widths, register offsets, STATUS bit positions and the TX FSM states.
package mr_uart_pkg;

    localparam int XLEN      = 32;
    localparam int XLEN_GRAN = 2;

    // Word offsets decoded from addr_i[1:0]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIV     = 2'd2;
    localparam logic [1:0] REG_INVALID = 2'd3;

    // STATUS register layout
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // FIFO occupancy squeezed into the 4-bit STATUS field; large FIFOs read as 15.
    function automatic logic [3:0] sat_count4(input int unsigned count);
        return (count > 15) ? 4'hF : count[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer update; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; only the pointers
        // define validity, and leaving it unreset lets it map onto plain RAM.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Transmit-only console UART on a pipelined Wishbone slave port.
// TXDATA pushes into a FIFO, the FSM serialises 8N1 LSB first on tx_o.
module wb_uart_tx
    import mr_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [XLEN-XLEN_GRAN-1:0] addr_i,
    input  logic                      we_i,
    input  logic [XLEN/8-1:0]         sel_i,
    input  logic [XLEN-1:0]           dat_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [XLEN-1:0]           dat_o,
    output logic                      stall_o,
    output logic                      tx_o,
    output logic                      irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]      reg_sel;
    logic            req;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      fifo_head;
    logic [XLEN-1:0] rdata_d;
    logic [XLEN-1:0] dat_q;
    logic            ack_q;
    logic            err_q;
    logic [15:0]     div_q;
    logic [15:0]     baud_load;
    tx_state_t       state_q;
    logic [15:0]     baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            unused_bits;

    assign unused_bits = ^{addr_i[XLEN-XLEN_GRAN-1:2], sel_i[XLEN/8-1:2], dat_i[XLEN-1:16]};

    assign reg_sel = addr_i[1:0];
    assign req     = cyc_i & stb_i;
    // Uses the pre-pop count, so a write may stall one cycle longer than needed.
    assign stall_o = req & we_i & (reg_sel == REG_TXDATA) & fifo_full;
    assign accept  = req & ~stall_o;
    assign push    = accept & we_i & (reg_sel == REG_TXDATA) & sel_i[0];

    // Head is consumed when a frame starts from IDLE or straight out of STOP.
    assign pop = ~fifo_empty &
                 ((state_q == IDLE) | ((state_q == STOP) && (baud_q == 16'd0)));

    // A divisor of 0 behaves as 1 clock per bit.
    assign baud_load = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (dat_i[7:0]),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Read-data mux for the addressed register.
    always_comb begin
        // NOTE: default every output of a combinational block first so no path
        // leaves it unassigned and a latch is never inferred.
        rdata_d = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata_d[STAT_BUSY]               = (state_q != IDLE);
                rdata_d[STAT_FULL]               = fifo_full;
                rdata_d[STAT_EMPTY]              = fifo_empty;
                rdata_d[STAT_COUNT_LSB +: 4]     = sat_count4(32'(fifo_count));
            end
            REG_DIV:    rdata_d[15:0] = div_q;
            default:    rdata_d = '0;
        endcase
    end

    // Registered single-cycle response for every accepted request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= accept & (reg_sel != REG_INVALID);
            err_q <= accept & (reg_sel == REG_INVALID);
            dat_q <= (accept & ~we_i & (reg_sel != REG_INVALID)) ? rdata_d : '0;
        end
    end

    // A dropped cycle cancels the response still in flight.
    assign ack_o = ack_q & cyc_i;
    assign err_o = err_q & cyc_i;
    assign dat_o = (ack_q & cyc_i) ? dat_q : '0;

    // Divisor register with per-byte-lane writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= DEFAULT_DIV;
        end else if (accept && we_i && (reg_sel == REG_DIV)) begin
            if (sel_i[0]) div_q[7:0]  <= dat_i[7:0];
            if (sel_i[1]) div_q[15:8] <= dat_i[15:8];
        end
    end

    // Transmit FSM: baud countdown reloaded only at bit starts, so divisor
    // changes never stretch or shorten the bit in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= START;
                        shift_q <= fifo_head;
                        baud_q  <= baud_load;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_q == 16'd0) begin
                        state_q <= DATA;
                        bit_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        baud_q  <= baud_load;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_q == 16'd0) begin
                        baud_q <= baud_load;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_q == 16'd0) begin
                        if (!fifo_empty) begin
                            state_q <= START;
                            shift_q <= fifo_head;
                            baud_q  <= baud_load;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = fifo_empty & (state_q == IDLE);

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register access, frame waveform, FIFO
// backpressure, divisor corner cases and reset abort.
module tb_wb_uart_tx;

    logic        clk_i;
    logic        rst_ni;
    logic [29:0] addr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic        err_o;
    logic [31:0] dat_o;
    logic        stall_o;
    logic        tx_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    // Serial monitor state
    bit         mon_en = 1'b0;
    int         mon_div = 1;
    bit         mon_busy = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_byte = '0;
    int         mon_stop_err = 0;
    logic [7:0] rx_q[$];
    int         start_q[$];

    wb_uart_tx dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .sel_i   (sel_i),
        .dat_i   (dat_i),
        .stb_i   (stb_i),
        .cyc_i   (cyc_i),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .dat_o   (dat_o),
        .stall_o (stall_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt++;

    // Frame decoder: start detected on the first low sample, each bit sampled
    // at its first cycle so any stretched or shortened bit corrupts the byte.
    always @(negedge clk_i) begin
        if (!mon_en) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_o === 1'b0) begin
                mon_busy = 1'b1;
                mon_t    = 0;
                start_q.push_back(cyc_cnt);
            end
        end else begin
            mon_t++;
            if ((mon_t % mon_div) == 0 && mon_t <= 8 * mon_div)
                mon_byte[mon_t / mon_div - 1] = tx_o;
            if (mon_t == 9 * mon_div && tx_o !== 1'b1)
                mon_stop_err++;
            if (mon_t == 10 * mon_div - 1) begin
                rx_q.push_back(mon_byte);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One Wishbone transfer; returns the response seen one cycle after acceptance.
    task automatic wb_xfer(input logic we, input logic [1:0] off, input logic [31:0] wdata,
                           input logic [3:0] sel, output logic ack, output logic err,
                           output logic [31:0] rdata, output int acc_cyc, output logic stalled);
        int n;
        @(negedge clk_i);
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        addr_i = {28'd0, off};
        dat_i  = wdata;
        sel_i  = sel;
        #1;
        stalled = stall_o;
        n = 0;
        while (stall_o === 1'b1 && n < 2000) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wb_stall_timeout: stall_o still %b after %0d cycles, required 0", stall_o, n);
        end
        @(negedge clk_i);
        ack     = ack_o;
        err     = err_o;
        rdata   = dat_o;
        acc_cyc = cyc_cnt;
        cyc_i   = 1'b0;
        stb_i   = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic test_reset();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac;
        rst_ni = 1'b0;
        cyc_i = 0; stb_i = 0; we_i = 0; addr_i = '0; sel_i = '0; dat_i = '0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({tx_o, irq_o, ack_o, err_o} !== 4'b1100 || dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b irq=%b ack=%b err=%b dat=%h, required 1 1 0 0 0",
                     tx_o, irq_o, ack_o, err_o, dat_o);
        end
        rst_ni = 1'b1;
        wb_xfer(1'b0, 2'd1, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (ack !== 1'b1 || rd !== 32'h4) begin
            errors++;
            $display("FAIL reset_status: ack=%b dat=%h, required ack=1 dat=00000004", ack, rd);
        end
        wb_xfer(1'b0, 2'd2, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (ack !== 1'b1 || rd !== 32'd868) begin
            errors++;
            $display("FAIL reset_div: ack=%b dat=%0d, required ack=1 dat=868", ack, rd);
        end
        wb_xfer(1'b0, 2'd0, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (ack !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL txdata_read: ack=%b dat=%h, required ack=1 dat=0", ack, rd);
        end
    endtask

    task automatic test_single_frame();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        wb_xfer(1'b1, 2'd2, 32'd4, 4'b0011, ack, err, rd, ac, stl);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL div_write_ack: ack=%b, required 1", ack);
        end
        wb_xfer(1'b1, 2'd0, 32'hA5, 4'b0001, ack, err, rd, ac, stl);
        // Now at cycle N+1: byte in FIFO, line still idle
        checks++;
        if (irq_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_n1: irq=%b tx=%b, required irq=0 tx=1", irq_o, tx_o);
        end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                checks++;
                if (tx_o !== frame[b] || irq_o !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_a5 bit%0d cyc%0d: tx=%b irq=%b, required tx=%b irq=0",
                             b, c, tx_o, irq_o, frame[b]);
                end
            end
        end
        @(negedge clk_i);
        checks++;
        if (irq_o !== 1'b1 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: irq=%b tx=%b, required irq=1 tx=1", irq_o, tx_o);
        end
    endtask

    // The first byte goes straight to the shift register, so nine writes fill
    // the eight-entry FIFO and the tenth has to wait for the next pop.
    task automatic test_back_to_back();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac, first_acc, n;
        logic [7:0] bytes [10];
        bytes = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'hFF, 8'h00, 8'h3C, 8'h96, 8'h7E, 8'hE1};
        wb_xfer(1'b1, 2'd2, 32'd2, 4'b0011, ack, err, rd, ac, stl);
        rx_q.delete();
        start_q.delete();
        mon_stop_err = 0;
        mon_div = 2;
        mon_en = 1'b1;
        first_acc = 0;
        for (int k = 0; k < 9; k++) begin
            wb_xfer(1'b1, 2'd0, {24'd0, bytes[k]}, 4'b0001, ack, err, rd, ac, stl);
            if (k == 0) first_acc = ac;
        end
        wb_xfer(1'b0, 2'd1, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'h83) begin
            errors++;
            $display("FAIL status_full: dat=%h, required 00000083", rd);
        end
        wb_xfer(1'b1, 2'd0, {24'd0, bytes[9]}, 4'b0001, ack, err, rd, ac, stl);
        checks++;
        if (stl !== 1'b1) begin
            errors++;
            $display("FAIL stall_seen: stall=%b, required 1", stl);
        end
        checks++;
        if (ac - first_acc != 22 || ack !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: accepted %0d cycles after first, ack=%b, required 22 and ack=1",
                     ac - first_acc, ack);
        end
        n = 0;
        while (rx_q.size() < 10 && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (rx_q.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: received %0d bytes, required 10", rx_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== bytes[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h, required %h", i, rx_q[i], bytes[i]);
                end
            end
        end
        for (int i = 0; i + 1 < start_q.size(); i++) begin
            checks++;
            if (start_q[i+1] - start_q[i] != 20) begin
                errors++;
                $display("FAIL b2b_spacing%0d: %0d cycles between starts, required 20",
                         i, start_q[i+1] - start_q[i]);
            end
        end
        checks++;
        if (mon_stop_err != 0) begin
            errors++;
            $display("FAIL b2b_stop_bits: %0d bad stop bits, required 0", mon_stop_err);
        end
        mon_en = 1'b0;
        n = 0;
        while (irq_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (irq_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: irq=%b, required 1", irq_o);
        end
    endtask

    task automatic test_err_and_sel();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac;
        wb_xfer(1'b0, 2'd3, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_read: err=%b ack=%b dat=%h, required err=1 ack=0 dat=0", err, ack, rd);
        end
        wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL err_write: err=%b ack=%b, required err=1 ack=0", err, ack);
        end
        wb_xfer(1'b1, 2'd0, 32'h0000_FF55, 4'b0010, ack, err, rd, ac, stl);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL nosel_ack: ack=%b err=%b, required ack=1 err=0", ack, err);
        end
        wb_xfer(1'b0, 2'd1, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'h4 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL nosel_status: dat=%h irq=%b, required 00000004 irq=1", rd, irq_o);
        end
        // DIV is still 2 from the previous test: the offset-3 write must not touch it
        wb_xfer(1'b0, 2'd2, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL err_no_side_effect: div=%0d, required 2", rd);
        end
    endtask

    task automatic test_div_edges();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac, n;
        wb_xfer(1'b1, 2'd2, 32'd0, 4'b0011, ack, err, rd, ac, stl);
        wb_xfer(1'b0, 2'd2, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL div0_read: dat=%0d, required 0", rd);
        end
        rx_q.delete();
        start_q.delete();
        mon_div = 1;
        mon_en = 1'b1;
        wb_xfer(1'b1, 2'd0, 32'h3C, 4'b0001, ack, err, rd, ac, stl);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (irq_o !== 1'b1 && n < 100);
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL div0_frame_len: irq high after %0d cycles, required 11", n);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            errors++;
            $display("FAIL div0_byte: %0d bytes, first %h, required 1 byte 3c",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        mon_en = 1'b0;

        // Divisor change during the start bit
        wb_xfer(1'b1, 2'd2, 32'd4, 4'b0011, ack, err, rd, ac, stl);
        wb_xfer(1'b1, 2'd0, 32'h55, 4'b0001, ack, err, rd, ac, stl);
        wb_xfer(1'b1, 2'd2, 32'd8, 4'b0011, ack, err, rd, ac, stl);
        checks++;
        if (tx_o !== 1'b0) begin
            errors++;
            $display("FAIL midbit_start: tx=%b, required 0", tx_o);
        end
        n = 0;
        forever begin
            @(negedge clk_i);
            if (tx_o !== 1'b0 || n > 50) break;
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL midbit_old_len: %0d more low cycles, required 2", n);
        end
        n = 1;
        forever begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || n > 50) break;
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL midbit_new_len: bit0 lasted %0d cycles, required 8", n);
        end
        n = 0;
        while (irq_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        wb_xfer(1'b1, 2'd2, 32'd4, 4'b0011, ack, err, rd, ac, stl);
    endtask

    task automatic test_reset_mid_frame();
        logic ack, err, stl;
        logic [31:0] rd;
        int ac, bad;
        for (int k = 0; k < 4; k++)
            wb_xfer(1'b1, 2'd0, 32'h00, 4'b0001, ack, err, rd, ac, stl);
        repeat (4) @(negedge clk_i);
        wb_xfer(1'b0, 2'd1, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'h31 || tx_o !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: status=%h tx=%b, required 00000031 tx=0", rd, tx_o);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (tx_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: tx=%b irq=%b, required 1 1", tx_o, irq_o);
        end
        rst_ni = 1'b1;
        wb_xfer(1'b0, 2'd1, 32'd0, 4'hF, ack, err, rd, ac, stl);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL post_reset_status: dat=%h, required 00000004", rd);
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: tx low on %0d cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_err_and_sel();
        test_div_edges();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
